multi_bit_multiplexer_nway_pipe: RTL and testbench
==================================================

// Module: multi_bit_multiplexer_nway_pipe
// PURPOSE
//   Parametrised N-way, WIDTH-bit multiplexer with a registered, flow-controlled output.
//   Selects one of NUM_INPUTS flattened data words per accepted request.
//   Buffers the result in a 2-entry skid buffer, so the block sustains one result per cycle under backpressure.
//   Sits between the 32 x 8-bit register file and the ALU/operand-fetch stage as the generalised read-port mux.
// PARAMETERS
//   WIDTH       8   bits per data word (>=1)
//   NUM_INPUTS  32  number of selectable words (>=2; need not be a power of 2)
//   SEL_W       $clog2(NUM_INPUTS)  select width (derived; must not be overridden)
// PORTS
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 asynchronous, active-low reset
//   data_in    in   NUM_INPUTS*WIDTH  word k occupies data_in[k*WIDTH +: WIDTH]
//   sel        in   SEL_W             index of the word to forward
//   in_valid   in   1                 request valid
//   in_ready   out  1                 block can accept a request
//   out_data   out  WIDTH             selected word
//   out_sel    out  SEL_W             sel value that produced out_data (tag)
//   out_valid  out  1                 out_data/out_sel valid
//   out_ready  in   1                 consumer accepts
//   out_err    out  1                 out_sel was out of range (present only with MUX_SEL_RANGE_CHECK_EN)
// BEHAVIOUR
//   - Reset (async assert, sync release): both buffer entries empty.
//     Reset values: out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=1.
//   - Accept: in_valid & in_ready at a rising edge.
//     The block samples data_in[sel] and sel in that same cycle; later changes to data_in do not affect the result.
//   - Latency: 1 cycle. A request accepted at edge N is presented with out_valid=1 after edge N.
//   - Output handshake: a word is consumed on out_valid & out_ready.
//     out_data, out_sel and out_err are held stable while out_valid & !out_ready.
//   - Skid buffer has 2 entries, count 0..2. Entries leave in acceptance order (FIFO order).
//     count 0: in_ready=1, out_valid=0.
//     count 1: in_ready=1, out_valid=1.
//     count 2: in_ready=0, out_valid=1.
//   - in_ready is a registered signal: it is a function of count only and never depends combinationally on out_ready.
//   - Simultaneous accept and consume at count 1: count stays at 1, and the new word is presented in the next cycle.
//     Simultaneous accept and consume at count 2 cannot occur, because in_ready=0.
//   - Out of range (sel >= NUM_INPUTS, possible only when NUM_INPUTS is not a power of 2): stored data is 0.
//   - Reset mid-operation: both entries are discarded immediately; no partial word is ever emitted.
//   - X on sel while in_valid=0 is ignored.
// CONFIGURATION
//   MUX_SEL_RANGE_CHECK_EN defined:
//     Each entry stores an err bit, set when sel >= NUM_INPUTS.
//     The err bit is presented on out_err alongside out_data; data stays 0 for such entries.
//   MUX_SEL_RANGE_CHECK_EN undefined:
//     Port out_err is absent and no err storage exists.
//     Out-of-range selects still yield out_data=0.
// STRUCTURE
//   - Shared include mux_defs.vh holds:
//     MUX_BUF_DEPTH (=2);
//     count encodings MUX_CNT_EMPTY / MUX_CNT_ONE / MUX_CNT_FULL;
//     a localparam macro for SEL_W derivation.
//   - Combinational select is an indexed part-select of data_in, with explicit zero for out-of-range indices.
//   - Sub-module mux_skid_buffer: 2-entry valid/ready buffer, parametrised on payload width.
//     Payload is WIDTH + SEL_W (+1 err bit with the macro).
//     This sub-module is reused by future pipelined read ports.
// TESTING
//   1. Reset and idle:
//      Assert rst_n=0 mid-cycle -> out_valid=0, out_data=0, in_ready=1 immediately.
//      Release rst_n -> no output until the first request is accepted.
//   2. Streaming with out_ready=1, WIDTH=8, NUM_INPUTS=32, data_in word k = 8'hA0+k:
//      sel = 0, 5, 31 on consecutive cycles -> out_data = A0, A5, BF on consecutive cycles,
//      out_sel = 0, 5, 31, latency 1, in_ready stays 1.
//   3. Backpressure: out_ready=0 while sel = 3, then 4 are sent
//      -> in_ready=0 after 2 accepts, out_data holds A3.
//      Raise out_ready -> A3 then A4 emerge, and in_ready returns to 1 one cycle after the first consume.
//   4. Input isolation: accept sel=7, then change word 7 to 8'h00 in the next cycle
//      -> out_data=A7 (sampled value).
//   5. Range check, NUM_INPUTS=24, macro defined: sel=30
//      -> out_data=0, out_err=1, out_sel=30.
//      Follow with sel=2 -> out_data=A2, out_err=0.
//      Same stimulus with the macro undefined -> out_data=0, and no out_err port exists.
//   6. Reset with count=2: assert rst_n=0 -> both entries are dropped.
//      After release, the next request sel=1 yields A1 only (no stale word is emitted).

Source files
------------

// File: rtl/multi_bit_multiplexer_nway_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_bit_multiplexer_nway_pipe_pkg
// Brief    : Shared definitions for the N-way pipelined read-port mux:
//            skid-buffer depth, occupancy encodings and select-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package multi_bit_multiplexer_nway_pipe_pkg;

    // Number of entries held by the output skid buffer.
    localparam int MUX_BUF_DEPTH = 2;

    // Occupancy of the skid buffer; also the state of its control FSM.
    typedef enum logic [1:0] {
        MUX_CNT_EMPTY = 2'd0,
        MUX_CNT_ONE   = 2'd1,
        MUX_CNT_FULL  = 2'd2
    } mux_cnt_e;

    // Select width for a given number of inputs; never narrower than 1 bit.
    function automatic int mux_sel_w(input int num_inputs);
        return (num_inputs <= 2) ? 1 : $clog2(num_inputs);
    endfunction

endpackage : multi_bit_multiplexer_nway_pipe_pkg
`default_nettype wire

// File: rtl/multi_bit_multiplexer_nway_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mux_skid_buffer
// Brief    : 2-entry valid/ready FIFO-ordered skid buffer with a registered
//            upstream ready. Generic payload width for reuse in other ports.
// Revision : 1.0 - initial release
// ============================================================================
module mux_skid_buffer
    import multi_bit_multiplexer_nway_pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 8
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PAYLOAD_W-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [PAYLOAD_W-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready
);

    logic [PAYLOAD_W-1:0] r_mem [MUX_BUF_DEPTH];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic                 r_ready;
    mux_cnt_e             r_cnt;
    mux_cnt_e             w_cnt_nxt;
    logic                 w_push;
    logic                 w_pop;

    assign w_push  = i_valid & r_ready;
    assign w_pop   = (r_cnt != MUX_CNT_EMPTY) & i_ready;
    assign o_valid = (r_cnt != MUX_CNT_EMPTY);
    assign o_ready = r_ready;
    assign o_data  = r_mem[r_rd_ptr];

    // Occupancy FSM next state; a push while full cannot happen because ready is low.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case (r_cnt)
            MUX_CNT_EMPTY: if (w_push)           w_cnt_nxt = MUX_CNT_ONE;
            MUX_CNT_ONE:   if (w_push && !w_pop) w_cnt_nxt = MUX_CNT_FULL;
                           else if (!w_push && w_pop) w_cnt_nxt = MUX_CNT_EMPTY;
            MUX_CNT_FULL:  if (w_pop)            w_cnt_nxt = MUX_CNT_ONE;
            default:                             w_cnt_nxt = MUX_CNT_EMPTY;
        endcase
    end

    // Occupancy register and registered ready, derived from next occupancy only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= MUX_CNT_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != MUX_CNT_FULL);
        end
    end

    // Entry storage and ring pointers; entries drain in acceptance order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUX_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

endmodule : mux_skid_buffer
`default_nettype wire

// File: rtl/multi_bit_multiplexer_nway_pipe.sv
`default_nettype none
// ============================================================================
// Module   : multi_bit_multiplexer_nway_pipe
// Brief    : NUM_INPUTS-way, WIDTH-bit read-port mux with a registered,
//            flow-controlled output through a 2-entry skid buffer.
//            Optional feature macro: MUX_SEL_RANGE_CHECK_EN (adds out_err).
//            SEL_W is derived from NUM_INPUTS and must not be overridden.
// Revision : 1.0 - initial release
// ============================================================================
module multi_bit_multiplexer_nway_pipe
    import multi_bit_multiplexer_nway_pipe_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 32,
    parameter int SEL_W      = mux_sel_w(NUM_INPUTS)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
`ifdef MUX_SEL_RANGE_CHECK_EN
    output logic                        out_err,
`endif
    output logic                        out_valid,
    input  logic                        out_ready
);

`ifdef MUX_SEL_RANGE_CHECK_EN
    localparam int c_PAYLOAD_W = WIDTH + SEL_W + 1;
`else
    localparam int c_PAYLOAD_W = WIDTH + SEL_W;
`endif
    localparam logic [SEL_W:0] c_NUM_INPUTS = (SEL_W + 1)'(NUM_INPUTS);

    logic                   w_sel_in_range;
    logic [WIDTH-1:0]       w_word;
    logic [c_PAYLOAD_W-1:0] w_in_payload;
    logic [c_PAYLOAD_W-1:0] w_out_payload;

    // Select the addressed word; indices past the last word read as zero.
    always_comb begin
        w_sel_in_range = ({1'b0, sel} < c_NUM_INPUTS);
        w_word         = '0;
        if (w_sel_in_range) begin
            w_word = data_in[int'(sel)*WIDTH +: WIDTH];
        end
    end

`ifdef MUX_SEL_RANGE_CHECK_EN
    assign w_in_payload = {~w_sel_in_range, w_word, sel};
    assign out_err      = w_out_payload[WIDTH+SEL_W];
`else
    assign w_in_payload = {w_word, sel};
`endif
    assign out_data = w_out_payload[SEL_W +: WIDTH];
    assign out_sel  = w_out_payload[0 +: SEL_W];

    mux_skid_buffer #(
        .PAYLOAD_W (c_PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (w_in_payload),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_data  (w_out_payload),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

endmodule : multi_bit_multiplexer_nway_pipe
`default_nettype wire

// File: tb/tb_multi_bit_multiplexer_nway_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_bit_multiplexer_nway_pipe
// Brief    : Scoreboard bench for the N-way pipelined mux: a 32-input and a
//            24-input instance, expected words queued on accept and compared
//            on consume. Honours MUX_SEL_RANGE_CHECK_EN for out_err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_bit_multiplexer_nway_pipe;

    typedef struct {
        logic [7:0] d;
        logic [4:0] s;
        logic       e;
        int         t;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [255:0]   data_in;
    logic [4:0]     sel;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [7:0]     out_data;
    logic [4:0]     out_sel;
    logic [191:0]   data24;
    logic [4:0]     sel24;
    logic           in_valid24, in_ready24, out_valid24, out_ready24;
    logic [7:0]     out_data24;
    logic [4:0]     out_sel24;
`ifdef MUX_SEL_RANGE_CHECK_EN
    logic           out_err, out_err24;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   lat_chk  = 1'b0;
    exp_t q[$];
    exp_t q24[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_bit_multiplexer_nway_pipe #(.WIDTH(8), .NUM_INPUTS(32)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel),
`ifdef MUX_SEL_RANGE_CHECK_EN
        .out_err(out_err),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    multi_bit_multiplexer_nway_pipe #(.WIDTH(8), .NUM_INPUTS(24)) dut24 (
        .clk(clk), .rst_n(rst_n), .data_in(data24), .sel(sel24),
        .in_valid(in_valid24), .in_ready(in_ready24),
        .out_data(out_data24), .out_sel(out_sel24),
`ifdef MUX_SEL_RANGE_CHECK_EN
        .out_err(out_err24),
`endif
        .out_valid(out_valid24), .out_ready(out_ready24)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard for the 32-input instance: pop on consume, push on accept.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_sel", 32'(out_sel), 32'(e.s));
`ifdef MUX_SEL_RANGE_CHECK_EN
                    check("out_err", 32'(out_err), 32'(e.e));
`endif
                    if (lat_chk) check("latency", 32'(cyc - e.t), 32'd1);
                end
            end
            if (in_valid && in_ready) begin
                e.s = sel;
                e.e = 1'b0;
                e.d = data_in[int'(sel)*8 +: 8];
                e.t = cyc;
                q.push_back(e);
            end
        end
    end

    // Scoreboard for the 24-input instance; selects 24..31 must read as zero.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid24 && out_ready24) begin
                check("sb24_nonempty", 32'(q24.size() != 0), 32'd1);
                if (q24.size() != 0) begin
                    e = q24.pop_front();
                    check("out_data24", 32'(out_data24), 32'(e.d));
                    check("out_sel24", 32'(out_sel24), 32'(e.s));
`ifdef MUX_SEL_RANGE_CHECK_EN
                    check("out_err24", 32'(out_err24), 32'(e.e));
`endif
                end
            end
            if (in_valid24 && in_ready24) begin
                e.s = sel24;
                e.e = (sel24 >= 5'd24);
                e.d = e.e ? 8'h00 : data24[int'(sel24)*8 +: 8];
                e.t = cyc;
                q24.push_back(e);
            end
        end
    end

    task automatic send(input logic [4:0] s);
        @(posedge clk); #1;
        in_valid = 1'b1;
        sel      = s;
        @(negedge clk);
        check("in_ready_at_send", 32'(in_ready), 32'd1);
    endtask

    task automatic send24(input logic [4:0] s);
        @(posedge clk); #1;
        in_valid24 = 1'b1;
        sel24      = s;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_valid24 = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (q.size() != 0 || q24.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        check(tag, 32'(q.size() + q24.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sel = '0; out_ready = 1'b1;
        in_valid24 = 1'b0; sel24 = '0; out_ready24 = 1'b1;
        for (int k = 0; k < 32; k++) data_in[k*8 +: 8] = 8'hA0 + 8'(k);
        for (int k = 0; k < 24; k++) data24[k*8 +: 8]  = 8'hA0 + 8'(k);

        // Reset and idle
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MUX_SEL_RANGE_CHECK_EN
        check("rst_out_err", 32'(out_err), 32'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_out_valid", 32'(out_valid), 32'd0);
        end

        // Streaming, latency 1
        lat_chk = 1'b1;
        send(5'd0); send(5'd5); send(5'd31);
        idle();
        drain("drain_stream");
        lat_chk = 1'b0;

        // Backpressure
        out_ready = 1'b0;
        send(5'd3); send(5'd4);
        idle();
        @(negedge clk);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_data", 32'(out_data), 32'hA3);
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_data", 32'(out_data), 32'hA3);
            check("bp_hold_sel", 32'(out_sel), 32'd3);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_before_consume", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp_in_ready_after_consume", 32'(in_ready), 32'd1);
        check("bp_second_word", 32'(out_data), 32'hA4);
        drain("drain_bp");

        // Input isolation: word 7 changes right after acceptance
        send(5'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in[7*8 +: 8] = 8'h00;
        @(negedge clk);
        check("iso_out_data", 32'(out_data), 32'hA7);
        drain("drain_iso");
        data_in[7*8 +: 8] = 8'hA7;

        // Out-of-range select on the 24-input instance
        send24(5'd30);
        send24(5'd2);
        idle();
        @(negedge clk);
        check("rng_second_data", 32'(out_data24), 32'hA2);
        drain("drain_range");

        // Reset while full
        out_ready = 1'b0;
        send(5'd10); send(5'd11);
        idle();
        @(negedge clk);
        check("full_before_rst", 32'(in_ready), 32'd0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_idle", 32'(out_valid), 32'd0);
        end
        lat_chk = 1'b1;
        send(5'd1);
        idle();
        @(negedge clk);
        check("postrst_data", 32'(out_data), 32'hA1);
        drain("drain_postrst");
        @(negedge clk);
        check("no_stale", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multi_bit_multiplexer_nway_pipe
`default_nettype wire
